// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin burst sequencer sharing one external mux8to1 among 8 requesters
// Optional idle-valid watchdog: define MUX8_ARB_TIMEOUT_EN.
module mux8_rr_arbiter #(
    parameter int Width         = 8,
    parameter int TimeoutCycles = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       reqValid,
    input  logic [7:0]       reqLast,
    output logic [7:0]       reqReady,
    output logic [2:0]       muxSelect,
    input  logic [Width-1:0] muxData,
    output logic             outValid,
    input  logic             outReady,
    output logic [Width-1:0] outData,
    output logic [2:0]       outSrc,
    output logic             outLast,
    output logic             busy,
    output logic             timeoutErr
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] ptr;
    logic [2:0] cand;
    logic [2:0] pick_idx;
    logic       pick_found;
    logic       space;
    logic       xfer;
    logic       burst_end;
    logic       abort;

    assign space = !outValid || outReady;
    assign busy  = (state == GRANT);

    // First valid requester scanning ptr, ptr+1, ... with 3-bit wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!pick_found && reqValid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] wd_cnt;

    assign abort = busy && !reqValid[muxSelect] && (wd_cnt == CntW'(TimeoutCycles - 1));

    // Only cycles where the granted source has nothing to offer are counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt     <= '0;
            timeoutErr <= 1'b0;
        end else begin
            timeoutErr <= abort;
            if (!busy || xfer || abort) begin
                wd_cnt <= '0;
            end else if (!reqValid[muxSelect]) begin
                wd_cnt <= wd_cnt + CntW'(1);
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TimeoutCycles >= 1);
    assign abort          = 1'b0;
    assign timeoutErr     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        reqReady   = '0;
        xfer       = 1'b0;
        burst_end  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                reqReady[muxSelect] = space;
                xfer                = reqValid[muxSelect] && space;
                burst_end           = xfer && reqLast[muxSelect];
                if (burst_end || abort) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 3'd0;
            muxSelect <= 3'd0;
            outValid  <= 1'b0;
            outData   <= '0;
            outSrc    <= 3'd0;
            outLast   <= 1'b0;
        end else begin
            if (state == IDLE && pick_found) begin
                muxSelect <= pick_idx;
            end
            // Refill takes priority so a same-cycle drain and refill keeps outValid high.
            if (xfer) begin
                outValid <= 1'b1;
                outData  <= muxData;
                outSrc   <= muxSelect;
                outLast  <= reqLast[muxSelect];
            end else if (outValid && outReady) begin
                outValid <= 1'b0;
            end
            if (burst_end || abort) begin
                ptr <= muxSelect + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - directed table, corner sequences and random run against a burst-level model
module tb_mux8_rr_arbiter;
    localparam int W  = 8;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   reqValid;
    logic [7:0]   reqLast;
    logic [7:0]   reqReady;
    logic [2:0]   muxSelect;
    logic [W-1:0] muxData;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outData;
    logic [2:0]   outSrc;
    logic         outLast;
    logic         busy;
    logic         timeoutErr;
    logic [W-1:0] dtab [8];

    int checks = 0;
    int passed = 0;

    // Model: owner is the granted requester (-1 when arbitrating), slot is the output beat.
    int m_owner, m_ptr, m_sel, m_cnt, m_od, m_osrc;
    bit m_ov, m_olast, m_terr;

    typedef struct {
        logic [7:0] rv;
        logic [7:0] rl;
        logic       ordy;
        logic [7:0] erdy;
        logic       eov;
        logic [7:0] eod;
        logic [2:0] esrc;
        logic       elast;
        logic       ebusy;
        logic [2:0] esel;
    } vec_t;

    mux8_rr_arbiter #(.Width(W), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqLast(reqLast), .reqReady(reqReady),
        .muxSelect(muxSelect), .muxData(muxData), .outValid(outValid), .outReady(outReady),
        .outData(outData), .outSrc(outSrc), .outLast(outLast), .busy(busy), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;
    assign muxData = dtab[muxSelect];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_sel = 0; m_cnt = 0;
        m_ov = 0; m_od = 0; m_osrc = 0; m_olast = 0; m_terr = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [7:0] rv, input logic [7:0] rl, input logic ordy,
                        output logic [7:0] rdy_seen);
        logic [7:0] er;
        bit         xfer;
        int         k;
        chk("outValid", outValid, m_ov);
        chk("outData", outData, m_od);
        chk("outSrc", outSrc, m_osrc);
        chk("outLast", outLast, m_olast);
        chk("busy", busy, m_owner >= 0);
        chk("muxSelect", muxSelect, m_sel);
        chk("timeoutErr", timeoutErr, m_terr);
        reqValid = rv; reqLast = rl; outReady = ordy;
        #1;
        rdy_seen = reqReady;
        er = '0;
        if (m_owner >= 0 && (!m_ov || ordy)) er[m_owner] = 1'b1;
        chk("reqReady", reqReady, er);
        xfer   = (m_owner >= 0) && rv[m_owner] && er[m_owner];
        m_terr = 0;
        if (xfer) begin
            m_ov = 1; m_od = dtab[m_owner]; m_osrc = m_owner; m_olast = rl[m_owner];
        end else if (m_ov && ordy) begin
            m_ov = 0;
        end
        if (m_owner < 0) begin
            for (k = 0; k < 8; k++) if (rv[(m_ptr + k) % 8]) break;
            if (k < 8) begin
                m_owner = (m_ptr + k) % 8; m_sel = m_owner; m_cnt = 0;
            end
        end else if (xfer) begin
            m_cnt = 0;
            if (rl[m_owner]) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1;
            end
        end else if (!rv[m_owner]) begin
`ifdef MUX8_ARB_TIMEOUT_EN
            m_cnt++;
            if (m_cnt == TO) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_terr = 1; m_cnt = 0;
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; reqValid = '0; reqLast = '0; outReady = 1'b0;
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        vec_t       vt [6];
        logic [7:0] rdy;
        logic [7:0] held;

        for (int i = 0; i < 8; i++) dtab[i] = W'(8'h10 + i);
        dtab[0] = 8'hA5;
        dtab[1] = 8'h5A;
        vt[0] = '{8'h01, 8'h01, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 3'd0};
        vt[1] = '{8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 8'hA5, 3'd0, 1'b1, 1'b0, 3'd0};
        vt[2] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b0, 3'd0};
        vt[3] = '{8'h03, 8'h03, 1'b1, 8'h00, 1'b0, 8'hA5, 3'd0, 1'b1, 1'b1, 3'd1};
        vt[4] = '{8'h03, 8'h03, 1'b1, 8'h02, 1'b1, 8'h5A, 3'd1, 1'b1, 1'b0, 3'd1};
        vt[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 3'd1, 1'b1, 1'b0, 3'd1};

        rst = 1'b1; reqValid = '0; reqLast = '0; outReady = 1'b0;
        @(negedge clk);
        chk("rst_outValid", outValid, 0);
        chk("rst_reqReady", reqReady, 0);
        chk("rst_busy", busy, 0);
        chk("rst_muxSelect", muxSelect, 0);
        chk("rst_outData", outData, 0);
        chk("rst_timeoutErr", timeoutErr, 0);
        model_reset();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            step(vt[i].rv, vt[i].rl, vt[i].ordy, rdy);
            chk("vec_reqReady", rdy, vt[i].erdy);
            chk("vec_outValid", outValid, vt[i].eov);
            chk("vec_outData", outData, vt[i].eod);
            chk("vec_outSrc", outSrc, vt[i].esrc);
            chk("vec_outLast", outLast, vt[i].elast);
            chk("vec_busy", busy, vt[i].ebusy);
            chk("vec_muxSelect", muxSelect, vt[i].esel);
        end

        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(8'hFF, 8'hFF, 1'b1, rdy);
            if (i % 2 == 1) begin
                chk("rr_outValid", outValid, 1);
                chk("rr_outSrc", outSrc, (i / 2) % 8);
                chk("rr_busy", busy, 0);
            end else begin
                chk("rr_arb_busy", busy, 1);
                chk("rr_arb_outValid", outValid, 0);
            end
        end

        do_reset();
        for (int b = 0; b < 5; b++) begin
            step(8'h24, (b == 4) ? 8'h24 : 8'h20, 1'b1, rdy);
            if (b > 0) begin
                chk("burst_reqReady", rdy, 8'h04);
                chk("burst_outSrc", outSrc, 2);
                chk("burst_outLast", outLast, b == 4);
            end
        end
        chk("burst_done_busy", busy, 0);
        step(8'h20, 8'h20, 1'b1, rdy);
        chk("burst_next_sel", muxSelect, 5);
        step(8'h20, 8'h20, 1'b1, rdy);
        chk("burst_next_ready", rdy, 8'h20);

        do_reset();
        step(8'h08, 8'h00, 1'b1, rdy);
        step(8'h08, 8'h00, 1'b1, rdy);
        held = outData;
        chk("stall_first", held, dtab[3]);
        for (int i = 0; i < 3; i++) begin
            dtab[3] = dtab[3] + 8'h11;
            step(8'h08, 8'h00, 1'b0, rdy);
            chk("stall_reqReady", rdy, 0);
            chk("stall_outData", outData, held);
        end
        step(8'h08, 8'h08, 1'b1, rdy);
        chk("stall_resume_ready", rdy, 8'h08);
        chk("stall_resume_data", outData, dtab[3]);

        do_reset();
        step(8'h40, 8'h00, 1'b1, rdy);
        step(8'h40, 8'h00, 1'b0, rdy);
        chk("pre_rst_outValid", outValid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_outValid", outValid, 0);
        chk("midrst_reqReady", reqReady, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_muxSelect", muxSelect, 0);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        step(8'h42, 8'h42, 1'b1, rdy);
        chk("postrst_sel", muxSelect, 1);

`ifdef MUX8_ARB_TIMEOUT_EN
        do_reset();
        step(8'h10, 8'h00, 1'b1, rdy);
        step(8'h10, 8'h00, 1'b1, rdy);
        for (int i = 0; i < TO; i++) step(8'h20, 8'h20, 1'b1, rdy);
        chk("to_pulse", timeoutErr, 1);
        chk("to_busy", busy, 0);
        step(8'h20, 8'h20, 1'b1, rdy);
        chk("to_next_sel", muxSelect, 5);
        chk("to_pulse_gone", timeoutErr, 0);
`endif

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 8; i++) dtab[i] = W'($urandom);
            step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), rdy);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
